// File: rtl/stream_wishbone_bridge.sv
// ============================================================================
// stream_wishbone_bridge : byte-stream command parser driving a Wishbone master
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stream_wishbone_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int ADDR_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy,
  output logic                    bus_error
);

  localparam int DB = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_BUS   = 3'd4,
    S_TX    = 3'd5
  } state_t;

  state_t                  state;
  logic                    is_write;
  logic                    is_inc;
  logic [7:0]              len;
  logic [7:0]              words;
  logic [7:0]              bcnt;
  logic [31:0]             tmo;
  logic [DATA_WIDTH-1:0]   rd_shift;

  logic                    accept;
  logic                    tx_take;
  logic                    bus_done;
  logic                    bus_fail;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign accept   = rx_valid & rx_ready;
  assign tx_take  = tx_valid & tx_ready;
  assign bus_done = wb_ack | wb_err | ((TIMEOUT != 0) && (tmo == 32'(TIMEOUT)));
  // ack together with err, or no ack at all (timeout), counts as a failed cycle
  assign bus_fail = wb_err | ~wb_ack;
  assign rd_word  = bus_fail ? '1 : wb_dat_r;

  assign wb_stb = wb_cyc;
  assign wb_sel = '1;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      wb_cyc    <= 1'b0;
      wb_we     <= 1'b0;
      wb_adr    <= '0;
      wb_dat_w  <= '0;
      bus_error <= 1'b0;
      is_write  <= 1'b0;
      is_inc    <= 1'b0;
      len       <= 8'h00;
      words     <= 8'h00;
      bcnt      <= 8'h00;
      tmo       <= 32'd0;
      rd_shift  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rx_ready <= 1'b1;
          if (accept) begin
            bus_error <= 1'b0;
            if (rx_data >= 8'h01 && rx_data <= 8'h04) begin
              is_write <= rx_data[0];
              is_inc   <= (rx_data <= 8'h02);
              state    <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (accept) begin
            len    <= rx_data;
            words  <= 8'h00;
            bcnt   <= 8'h00;
            wb_adr <= '0;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (accept) begin
            // big-endian shift-in; bytes beyond ADDR_WIDTH fall off the top
            wb_adr <= (wb_adr << 8) | ADDR_WIDTH'(rx_data);
            bcnt   <= bcnt + 8'd1;
            if (bcnt == 8'(ADDR_BYTES - 1)) begin
              bcnt <= 8'h00;
              if (len == 8'h00) begin
                state <= S_IDLE;
              end else if (is_write) begin
                state <= S_WDATA;
              end else begin
                state    <= S_BUS;
                rx_ready <= 1'b0;
                wb_cyc   <= 1'b1;
                wb_we    <= 1'b0;
                tmo      <= 32'd1;
              end
            end
          end
        end
        S_WDATA: begin
          if (accept) begin
            wb_dat_w <= (wb_dat_w << 8) | DATA_WIDTH'(rx_data);
            bcnt     <= bcnt + 8'd1;
            if (bcnt == 8'(DB - 1)) begin
              bcnt     <= 8'h00;
              state    <= S_BUS;
              rx_ready <= 1'b0;
              wb_cyc   <= 1'b1;
              wb_we    <= 1'b1;
              tmo      <= 32'd1;
            end
          end
        end
        S_BUS: begin
          if (bus_done) begin
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            words  <= words + 8'd1;
            if (bus_fail) bus_error <= 1'b1;
            if (is_write) begin
              rx_ready <= 1'b1;
              if (words + 8'd1 == len) begin
                state <= S_IDLE;
              end else begin
                state <= S_WDATA;
                if (is_inc) wb_adr <= wb_adr + 1'b1;
              end
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= rd_word[DATA_WIDTH-1 -: 8];
              rd_shift <= rd_word << 8;
              state    <= S_TX;
            end
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        S_TX: begin
          if (tx_take) begin
            if (bcnt == 8'(DB - 1)) begin
              bcnt     <= 8'h00;
              tx_valid <= 1'b0;
              if (words == len) begin
                state    <= S_IDLE;
                rx_ready <= 1'b1;
              end else begin
                if (is_inc) wb_adr <= wb_adr + 1'b1;
                wb_cyc <= 1'b1;
                tmo    <= 32'd1;
                state  <= S_BUS;
              end
            end else begin
              tx_data  <= rd_shift[DATA_WIDTH-1 -: 8];
              rd_shift <= rd_shift << 8;
              bcnt     <= bcnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_wishbone_bridge.sv
// ============================================================================
// tb_stream_wishbone_bridge : directed + randomized frames against a frame-level model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stream_wishbone_bridge;

  localparam int DW = 32;
  localparam int AW = 30;
  localparam int AB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_w;
  logic [DW-1:0] wb_dat_r;
  logic [DW/8-1:0] wb_sel;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic          busy, bus_error;

  always #5 clk = ~clk;

  stream_wishbone_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_BYTES(AB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .bus_error(bus_error)
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    int            dur;
    bit            bad;
  } bus_t;

  int compared   = 0;
  int mismatched = 0;

  bus_t          obs_bus[$];
  bus_t          exp_bus[$];
  logic [7:0]    obs_tx[$];
  logic [7:0]    exp_tx[$];
  logic [DW-1:0] smem[logic [AW-1:0]];
  logic [DW-1:0] model_mem[logic [AW-1:0]];
  logic [DW-1:0] wd[$];
  int            slave_mode  = 0;  // 0 ack, 1 err, 2 silent, 3 ack+err
  int            slave_waits = 0;
  bit            slave_in_cyc = 0;
  bit            tx_rand = 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a, 2'b10} ^ 32'hC3A5_0F17;
  endfunction

  function automatic logic [DW-1:0] smem_rd(input logic [AW-1:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed no progress expected completion", tag);
  endtask

  // Wishbone slave + bus monitor
  initial begin : slave
    bus_t cur;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    cur = '{adr: '0, we: 1'b0, dat: '0, dur: 0, bad: 1'b0};
    forever begin
      @(negedge clk);
      if (wb_stb === 1'b1) begin
        if (!slave_in_cyc) begin
          slave_in_cyc = 1;
          cur.adr = wb_adr; cur.we = wb_we; cur.dat = wb_dat_w; cur.dur = 0; cur.bad = 0;
        end else if (wb_adr !== cur.adr || wb_we !== cur.we || wb_dat_w !== cur.dat) begin
          cur.bad = 1;
        end
        if (wb_cyc !== 1'b1 || wb_sel !== {(DW/8){1'b1}}) cur.bad = 1;
        cur.dur++;
        if (cur.dur > slave_waits && slave_mode != 2) begin
          wb_ack = (slave_mode == 0 || slave_mode == 3);
          wb_err = (slave_mode == 1 || slave_mode == 3);
          if (slave_mode == 0) begin
            if (cur.we) smem[cur.adr] = cur.dat;
            wb_dat_r = smem_rd(cur.adr);
          end else begin
            wb_dat_r = $urandom;
          end
        end
      end else begin
        if (slave_in_cyc) begin
          obs_bus.push_back(cur);
          slave_in_cyc = 0;
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
    end
  end

  // TX sink: a byte counts when tx_valid & tx_ready hold across the next posedge
  initial begin : tx_sink
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid === 1'b1 && tx_ready) obs_tx.push_back(tx_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) expire("rx_stall");
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((busy !== 1'b0 || slave_in_cyc) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) expire("idle_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    smem[a]      = v;
    model_mem[a] = v;
  endtask

  // Frame-level reference: expected bus cycles and tx bytes derived from the command rules
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr,
                           input int mode, input int waits, input string tag);
    logic [AW-1:0] base, a;
    logic [DW-1:0] v;
    bit wr, inc, ok, eberr;
    bus_t e;
    int n;
    base = addr[AW-1:0];
    wr   = (cmd == 8'h01 || cmd == 8'h03);
    inc  = (cmd == 8'h01 || cmd == 8'h02);
    ok   = (mode == 0);
    eberr = 0;
    exp_bus.delete(); exp_tx.delete(); obs_bus.delete(); obs_tx.delete();
    slave_mode = mode; slave_waits = waits;
    for (int k = 0; k < int'(len); k++) begin
      a = inc ? base + AW'(k) : base;
      e.adr = a; e.we = wr; e.dat = wr ? wd[k] : '0; e.bad = 0;
      e.dur = (mode == 2) ? TO : waits + 1;
      exp_bus.push_back(e);
      if (!ok) eberr = 1;
      if (wr) begin
        if (ok) model_mem[a] = wd[k];
      end else begin
        v = ok ? model_rd(a) : '1;
        for (int b = DW/8 - 1; b >= 0; b--) exp_tx.push_back(v[b*8 +: 8]);
      end
    end

    send_byte(cmd);
    chk({tag, ".berr_clear"}, 64'(bus_error), 64'd0);
    send_byte(len);
    for (int i = AB - 1; i >= 0; i--) send_byte(addr[i*8 +: 8]);
    if (wr) begin
      for (int k = 0; k < int'(len); k++)
        for (int b = DW/8 - 1; b >= 0; b--) send_byte(wd[k][b*8 +: 8]);
    end
    wait_idle();

    chk({tag, ".nbus"}, 64'(obs_bus.size()), 64'(exp_bus.size()));
    n = (obs_bus.size() < exp_bus.size()) ? obs_bus.size() : exp_bus.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.adr%0d", tag, i), 64'(obs_bus[i].adr), 64'(exp_bus[i].adr));
      chk($sformatf("%s.we%0d", tag, i), 64'(obs_bus[i].we), 64'(exp_bus[i].we));
      if (exp_bus[i].we) chk($sformatf("%s.dat%0d", tag, i), 64'(obs_bus[i].dat), 64'(exp_bus[i].dat));
      chk($sformatf("%s.dur%0d", tag, i), 64'(obs_bus[i].dur), 64'(exp_bus[i].dur));
      chk($sformatf("%s.stable%0d", tag, i), 64'(obs_bus[i].bad), 64'(exp_bus[i].bad));
    end
    chk({tag, ".ntx"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    n = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s.tx%0d", tag, i), 64'(obs_tx[i]), 64'(exp_tx[i]));
    chk({tag, ".bus_error"}, 64'(bus_error), 64'(eberr));
  endtask

  initial begin : main
    logic [7:0]  rcmd, rlen;
    logic [31:0] raddr;
    int p, rmode;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.rx_ready", 64'(rx_ready), 64'd0);
    chk("rst.tx_valid", 64'(tx_valid), 64'd0);
    chk("rst.tx_data", 64'(tx_data), 64'd0);
    chk("rst.wb_cyc", 64'(wb_cyc), 64'd0);
    chk("rst.wb_stb", 64'(wb_stb), 64'd0);
    chk("rst.wb_we", 64'(wb_we), 64'd0);
    chk("rst.wb_adr", 64'(wb_adr), 64'd0);
    chk("rst.wb_dat_w", 64'(wb_dat_w), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.bus_error", 64'(bus_error), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rx_ready_rise", 64'(rx_ready), 64'd1);

    wd = '{32'h0000_000E};
    run_frame(8'h01, 8'd1, 32'h0000_9000, 0, 0, "t1_write");

    preload(30'h9004, 32'h11); preload(30'h9005, 32'h22); preload(30'h9006, 32'h33);
    tx_rand = 1;
    run_frame(8'h02, 8'd3, 32'h0000_9004, 0, 2, "t2_read");

    wd = '{32'h0000_0200, 32'h0000_0002};
    run_frame(8'h03, 8'd2, 32'h0000_900C, 0, 1, "t3_fixed");

    run_frame(8'h02, 8'd1, 32'h0000_9010, 2, 0, "t4_timeout");

    obs_bus.delete(); obs_tx.delete();
    send_byte(8'h7F);
    repeat (3) @(negedge clk);
    chk("t5_unknown.busy", 64'(busy), 64'd0);
    chk("t5_unknown.bus_error", 64'(bus_error), 64'd0);
    chk("t5_unknown.nbus", 64'(obs_bus.size()), 64'd0);
    wd = '{32'hDEAD_BEEF};
    run_frame(8'h01, 8'd1, 32'h0000_9008, 0, 0, "t5_write");
    run_frame(8'h02, 8'd0, 32'h0000_9000, 0, 0, "t5_len0");

    obs_bus.delete();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h90); send_byte(8'h04); send_byte(8'hAA);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst.busy", 64'(busy), 64'd0);
    chk("t6_rst.rx_ready", 64'(rx_ready), 64'd0);
    chk("t6_rst.wb_adr", 64'(wb_adr), 64'd0);
    chk("t6_rst.wb_dat_w", 64'(wb_dat_w), 64'd0);
    chk("t6_rst.wb_cyc", 64'(wb_cyc), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst.nbus", 64'(obs_bus.size()), 64'd0);
    wd = '{32'h1234_5678};
    run_frame(8'h01, 8'd1, 32'h0000_9004, 0, 0, "t6_after_rst");

    for (int r = 0; r < 24; r++) begin
      rcmd  = 8'($urandom_range(1, 4));
      rlen  = 8'($urandom_range(0, 4));
      raddr = $urandom;
      if (r % 4 == 0) raddr[AW-1:0] = 30'h3FFF_FFFE;
      p = $urandom_range(0, 9);
      rmode = (p < 7) ? 0 : (p == 7) ? 1 : (p == 8) ? 3 : 2;
      wd.delete();
      for (int k = 0; k < int'(rlen); k++) wd.push_back($urandom);
      run_frame(rcmd, rlen, raddr, rmode, $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
